key_schedule_unit: RTL and testbench

KEY_SCHEDULE_UNIT -- requirements
Module: key_schedule_unit

---
 rtl/key_schedule_unit.sv | 198 +++++++++++++++++++
 tb/tb_key_schedule_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_unit.sv
// AES key expansion (128/192/256) with word storage and a registered round-key read port.
// Optional storage clear feature selected by macro KEYSCHED_ZEROIZE_EN.

module key_schedule_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry x sits at bit offset (255-x)*8, and 255-x is just ~x.
  logic [10:0] w_base;
  assign w_base = {~i_byte, 3'b000};
  assign o_byte = SBOX[w_base +: 8];
endmodule

module key_schedule_unit #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                zeroize,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic                rd_valid,
  output logic                rd_err
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);

`ifdef KEYSCHED_ZEROIZE_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE, S_ZERO} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;
`endif

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic [31:0] r_w [TW];

  logic [31:0]  w_prev, w_back, w_rot, w_sub_in, w_sub_out, w_t, w_new;
  logic         w_idle_like, w_go_zero, w_go_load, w_rd_ok;
  logic [5:0]   w_rd_base;
  logic [127:0] w_rd_key;
  logic [7:0]   w_rcon_next;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef KEYSCHED_ZEROIZE_EN
  logic [5:0] r_zidx;
  logic       r_zpend;
  assign w_go_zero = w_idle_like && (zeroize || r_zpend);
`else
  logic w_unused_zeroize;
  assign w_unused_zeroize = zeroize;
  assign w_go_zero = 1'b0;
`endif

  assign w_go_load = w_idle_like && start && !w_go_zero;

  // r_idx never leaves [NK, TW-1], so both taps stay in range.
  assign w_prev   = r_w[r_idx - 6'd1];
  assign w_back   = r_w[r_idx - 6'(NK)];
  assign w_rot    = {w_prev[23:0], w_prev[31:24]};
  assign w_sub_in = (r_mod == 3'd0) ? w_rot : w_prev;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      key_schedule_sbox u_sbox (
        .i_byte (w_sub_in[8*gi +: 8]),
        .o_byte (w_sub_out[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    w_t = w_prev;
    if (r_mod == 3'd0)
      w_t = w_sub_out ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_mod == 3'd4)
      w_t = w_sub_out;
  end

  assign w_new       = w_back ^ w_t;
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  assign w_rd_ok   = done && (rd_round <= 4'(NR));
  assign w_rd_base = w_rd_ok ? {rd_round, 2'b00} : 6'd0;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign w_rd_key[127-32*gi -: 32] = r_w[w_rd_base + 6'(gi)];
    end
  endgenerate

  // Word storage carries no reset; stale contents are unreadable until done.
  always_ff @(posedge clk) begin
    if (w_go_load) begin
      for (int k = 0; k < NK; k++)
        r_w[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[r_idx] <= w_new;
    end
`ifdef KEYSCHED_ZEROIZE_EN
    else if (r_state == S_ZERO) begin
      r_w[r_zidx] <= 32'h0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_state  <= S_IDLE;
      r_idx    <= 6'(NK);
      r_mod    <= 3'd0;
      r_rcon   <= 8'h01;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
`ifdef KEYSCHED_ZEROIZE_EN
      r_zidx   <= 6'd0;
      r_zpend  <= 1'b1;
`endif
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err <= !w_rd_ok;
        rd_key <= w_rd_ok ? w_rd_key : 128'h0;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go_zero) begin
`ifdef KEYSCHED_ZEROIZE_EN
            r_state <= S_ZERO;
            r_zidx  <= 6'd0;
            r_zpend <= 1'b0;
`endif
            busy    <= 1'b1;
            done    <= 1'b0;
          end else if (w_go_load) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state <= S_EXPAND;
          r_idx   <= 6'(NK);
          r_mod   <= 3'd0;
          r_rcon  <= 8'h01;
        end
        S_EXPAND: begin
          if (r_mod == 3'd0)
            r_rcon <= w_rcon_next;
          if (r_idx == 6'(TW - 1)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_idx <= r_idx + 6'd1;
            r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
          end
        end
`ifdef KEYSCHED_ZEROIZE_EN
        S_ZERO: begin
          if (r_zidx == 6'(TW - 1)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_zidx <= r_zidx + 6'd1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_unit.sv
// Directed bench for key_schedule_unit: one instance per key size, FIPS-197 vectors.
// Covers the zeroize path when KEYSCHED_ZEROIZE_EN is defined.

module tb_key_schedule_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rest, zeroize, rd_en;
  logic [3:0]   rd_round;
  logic         st128, st192, st256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;

  logic         busy128, busy192, busy256;
  logic         done128, done192, done256;
  logic [127:0] rk128, rk192, rk256;
  logic         rv128, rv192, rv256;
  logic         re128, re192, re256;

  int n_checks = 0;
  int n_errors = 0;

  key_schedule_unit #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rest(rest), .start(st128), .key_in(key128), .zeroize(zeroize),
    .busy(busy128), .done(done128), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk128), .rd_valid(rv128), .rd_err(re128));

  key_schedule_unit #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rest(rest), .start(st192), .key_in(key192), .zeroize(zeroize),
    .busy(busy192), .done(done192), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk192), .rd_valid(rv192), .rd_err(re192));

  key_schedule_unit #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rest(rest), .start(st256), .key_in(key256), .zeroize(zeroize),
    .busy(busy256), .done(done256), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk256), .rd_valid(rv256), .rd_err(re256));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic sel_done(input int sel);
    return (sel == 0) ? done128 : (sel == 1) ? done192 : done256;
  endfunction
  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy128 : (sel == 1) ? busy192 : busy256;
  endfunction
  function automatic logic sel_valid(input int sel);
    return (sel == 0) ? rv128 : (sel == 1) ? rv192 : rv256;
  endfunction
  function automatic logic sel_err(input int sel);
    return (sel == 0) ? re128 : (sel == 1) ? re192 : re256;
  endfunction
  function automatic logic [127:0] sel_key(input int sel);
    return (sel == 0) ? rk128 : (sel == 1) ? rk192 : rk256;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy128 || busy192 || busy256) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, " idle"}, 128'(busy128 | busy192 | busy256), 128'd0);
  endtask

  // Start expansion and count edges until done; the 128-bit run also pokes a
  // junk start mid-expansion, which must be ignored.
  task automatic expand(input int sel, input int exp_lat, input string tag);
    int n = 0;
    logic [127:0] saved = key128;
    case (sel)
      0:       st128 = 1'b1;
      1:       st192 = 1'b1;
      default: st256 = 1'b1;
    endcase
    @(posedge clk); #1;
    st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
    check_val({tag, " done_drop"}, 128'(sel_done(sel)), 128'd0);
    check_val({tag, " busy"}, 128'(sel_busy(sel)), 128'd1);
    while (!sel_done(sel) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (sel == 0 && n == 5) begin
        key128 = ~saved;
        st128  = 1'b1;
      end else if (sel == 0 && n == 6) begin
        key128 = saved;
        st128  = 1'b0;
      end
    end
    check_val({tag, " latency"}, 128'(n), 128'(exp_lat));
  endtask

  task automatic read_chk(input int sel, input logic [3:0] r, input logic exp_err,
                          input logic [127:0] exp_key, input string tag);
    rd_en = 1'b1; rd_round = r;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check_val({tag, " valid"}, 128'(sel_valid(sel)), 128'd1);
    check_val({tag, " err"}, 128'(sel_err(sel)), 128'(exp_err));
    check_val({tag, " key"}, sel_key(sel), exp_key);
    @(posedge clk); #1;
    check_val({tag, " pulse_end"}, 128'(sel_valid(sel)), 128'd0);
  endtask

  initial begin
    rest = 1'b1; zeroize = 1'b0; rd_en = 1'b0; rd_round = 4'd0;
    st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", 128'(busy128), 128'd0);
    check_val("rst done", 128'(done128), 128'd0);
    check_val("rst rd_valid", 128'(rv128), 128'd0);
    check_val("rst rd_err", 128'(re128), 128'd0);
    check_val("rst rd_key", rk128, 128'd0);
    rest = 1'b0;
    wait_idle("post_rst");

    read_chk(0, 4'd0, 1'b1, 128'd0, "nodone_rd");

    // Abort an expansion with a reset pulse around cycle 20.
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    st128 = 1'b1;
    @(posedge clk); #1;
    st128 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check_val("abort busy_pre", 128'(busy128), 128'd1);
    rest = 1'b1;
    #1;
    check_val("abort busy_async", 128'(busy128), 128'd0);
    check_val("abort done_async", 128'(done128), 128'd0);
    @(posedge clk); #1;
    rest = 1'b0;
    wait_idle("abort");
    check_val("abort done", 128'(done128), 128'd0);

    key128 = 128'h000102030405060708090a0b0c0d0e0f;
    expand(0, 41, "k128_seq");
    read_chk(0, 4'd10, 1'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k128_seq r10");

    // Restart from DONE with the FIPS key.
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(0, 41, "k128_fips");
    read_chk(0, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128 r10");
    read_chk(0, 4'd0, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "k128 r0");

    // Back-to-back reads: round 1 then out-of-range round 11.
    rd_en = 1'b1; rd_round = 4'd1;
    @(posedge clk); #1;
    rd_round = 4'd11;
    check_val("b2b r1 valid", 128'(rv128), 128'd1);
    check_val("b2b r1 err", 128'(re128), 128'd0);
    check_val("b2b r1 key", rk128, 128'ha0fafe1788542cb123a339392a6c7605);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check_val("b2b r11 valid", 128'(rv128), 128'd1);
    check_val("b2b r11 err", 128'(re128), 128'd1);
    check_val("b2b r11 key", rk128, 128'd0);
    @(posedge clk); #1;
    check_val("b2b pulse_end", 128'(rv128), 128'd0);

    key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    expand(1, 47, "k192");
    read_chk(1, 4'd12, 1'b0, 128'ha4970a331a78dc09c418c271e3a41d5d, "k192 r12");
    read_chk(1, 4'd0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f, "k192 r0");
    read_chk(1, 4'd13, 1'b1, 128'd0, "k192 r13");

    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    expand(2, 53, "k256");
    read_chk(2, 4'd14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256 r14");
    read_chk(2, 4'd1, 1'b0, 128'h101112131415161718191a1b1c1d1e1f, "k256 r1");

`ifdef KEYSCHED_ZEROIZE_EN
    begin
      int n = 0;
      zeroize = 1'b1;
      @(posedge clk); #1;
      zeroize = 1'b0;
      check_val("zero done", 128'(done128), 128'd0);
      while (busy128 && n < 200) begin
        n++;
        @(posedge clk); #1;
      end
      check_val("zero busy_cycles", 128'(n), 128'd44);
      read_chk(0, 4'd10, 1'b1, 128'd0, "zero rd");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
